plot_fb_writer: RTL and testbench

- Receiving end of the VGA plot interface (vga_x/vga_y/vga_colour/vga_plot) driven by fillscreen and later drawing engines.
- Accepts at most one plot request per cycle and range-checks it against the 160x120 screen.
- Linearises coordinates to a framebuffer address and buffers requests in a small FIFO.
- Drains the FIFO to a framebuffer memory write port with valid/ready backpressure; sits between drawing blocks and the framebuffer RAM.

---
 rtl/plot_pkg.sv | 21 ++
 rtl/plot_fifo.sv | 62 ++++++
 rtl/plot_fb_writer.sv | 120 ++++++++++++
 tb/tb_plot_fb_writer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// Shared screen geometry, FIFO entry type and address linearisation for the plot write path.
package plot_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOUR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } plot_entry_t;

  // y*160 + x built from shifts: y*128 + y*32 + x, never exceeds 19199.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] y_ext;
    y_ext = ADDR_W'(y);
    return (y_ext << 7) + (y_ext << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Show-ahead FIFO of plot entries; head entry is visible on dout while not empty.
module plot_fifo
  import plot_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  plot_entry_t              din,
  output plot_entry_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  plot_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == (PTR_W+1)'(DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/plot_fb_writer.sv
// VGA plot receiver: range check, FIFO buffering and framebuffer write drain with backpressure.
// Optional macro PLOT_STATS_EN adds the drop_count output.
module plot_fb_writer
  import plot_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SAT_MAX = 19200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          vga_x,
  input  logic [6:0]          vga_y,
  input  logic [COLOUR_W-1:0] vga_colour,
  input  logic                vga_plot,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_colour,
  output logic                mem_wr,
  input  logic                mem_ready,
  output logic                busy,
  output logic                overflow,
  input  logic                clr_flags,
`ifdef PLOT_STATS_EN
  output logic [7:0]          drop_count,
`endif
  output logic [14:0]         pix_count
);

  localparam logic [14:0] PIX_SAT = 15'(SAT_MAX);

  logic                   w_in_range;
  logic                   w_valid;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  plot_entry_t            w_din;
  plot_entry_t            w_dout;
  plot_entry_t            r_hold;
  logic                   r_overflow;
  logic [14:0]            r_pix_count;

  assign w_in_range = (vga_x < 8'(SCREEN_W)) && (vga_y < 7'(SCREEN_H));
  assign w_valid    = vga_plot && w_in_range;
  assign w_pop      = !w_empty && mem_ready;
  assign w_push     = w_valid && (!w_full || w_pop);
  assign w_din      = '{addr: to_addr(vga_x, vga_y), colour: vga_colour};

  plot_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // The RAM slot behind an empty head may hold anything, so the last head is kept visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (!w_empty) begin
      r_hold <= w_dout;
    end
  end

  assign mem_wr     = !w_empty;
  assign busy       = (w_count != '0);
  assign mem_addr   = w_empty ? r_hold.addr : w_dout.addr;
  assign mem_colour = w_empty ? r_hold.colour : w_dout.colour;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (clr_flags) begin
      r_overflow <= 1'b0;
    end else if (w_valid && !w_push) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_count <= '0;
    end else if (clr_flags) begin
      r_pix_count <= '0;
    end else if (w_pop && (r_pix_count != PIX_SAT)) begin
      r_pix_count <= r_pix_count + 15'd1;
    end
  end

  assign overflow  = r_overflow;
  assign pix_count = r_pix_count;

`ifdef PLOT_STATS_EN
  logic [7:0] r_drop_count;
  logic       w_drop;

  // Counts both out-of-range requests and valid ones lost to a full FIFO.
  assign w_drop = vga_plot && !w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (clr_flags) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_plot_fb_writer.sv
// Directed self-checking bench for plot_fb_writer; expected values are hand-computed constants.
module tb_plot_fb_writer;
  import plot_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [14:0] mem_addr;
  logic [2:0]  mem_colour;
  logic        mem_wr;
  logic        mem_ready;
  logic        busy;
  logic        overflow;
  logic        clr_flags;
  logic [14:0] pix_count;
`ifdef PLOT_STATS_EN
  logic [7:0]  drop_count;
`endif

  int vecs;
  int errs;
  int sweep_bad;
  int sweep_first;
  int exp_addr;

  plot_fb_writer #(
    .DEPTH   (4),
    .SAT_MAX (19200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .mem_addr   (mem_addr),
    .mem_colour (mem_colour),
    .mem_wr     (mem_wr),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .overflow   (overflow),
    .clr_flags  (clr_flags),
`ifdef PLOT_STATS_EN
    .drop_count (drop_count),
`endif
    .pix_count  (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic plot(input int x, input int y, input int c);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 3'(c);
    vga_plot   = 1'b1;
  endtask

  initial begin
    vecs = 0; errs = 0; sweep_bad = 0; sweep_first = -1;
    rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    mem_ready = 1'b0; clr_flags = 1'b0;
    tick();
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_colour", 32'(mem_colour), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_pix", 32'(pix_count), 0);
    rst = 1'b0;
    tick();

    // Single plot (5,3) -> 3*160+5 = 485
    mem_ready = 1'b1;
    plot(5, 3, 5);
    tick();
    vga_plot = 1'b0;
    chk("single_wr", 32'(mem_wr), 1);
    chk("single_addr", 32'(mem_addr), 485);
    chk("single_colour", 32'(mem_colour), 5);
    chk("single_pix0", 32'(pix_count), 0);
    tick();
    chk("single_pix1", 32'(pix_count), 1);
    chk("single_drained", 32'(mem_wr), 0);
    chk("single_hold_addr", 32'(mem_addr), 485);

    // Out-of-range requests
    plot(160, 0, 1);
    tick();
    chk("oor_a_wr", 32'(mem_wr), 0);
    plot(0, 120, 2);
    tick();
    chk("oor_b_wr", 32'(mem_wr), 0);
    plot(255, 127, 3);
    tick();
    vga_plot = 1'b0;
    chk("oor_c_wr", 32'(mem_wr), 0);
    chk("oor_busy", 32'(busy), 0);
    chk("oor_overflow", 32'(overflow), 0);
`ifdef PLOT_STATS_EN
    chk("oor_drops", 32'(drop_count), 3);
`endif

    // Backpressure: 6 plots into depth 4 -> addr 1600+i, last two dropped
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      plot(i, 10, i);
      tick();
    end
    vga_plot = 1'b0;
    chk("bp_count", 32'(dut.w_count), 4);
    chk("bp_overflow", 32'(overflow), 1);
    chk("bp_wr", 32'(mem_wr), 1);
    chk("bp_addr", 32'(mem_addr), 1600);
    tick();
    chk("bp_stall_addr1", 32'(mem_addr), 1600);
    tick();
    chk("bp_stall_addr2", 32'(mem_addr), 1600);
    chk("bp_stall_colour", 32'(mem_colour), 0);
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_drain_addr%0d", k), 32'(mem_addr), 32'(1600 + k));
      chk($sformatf("bp_drain_col%0d", k), 32'(mem_colour), 32'(k));
      tick();
    end
    chk("bp_empty", 32'(mem_wr), 0);
    chk("bp_pix", 32'(pix_count), 5);
`ifdef PLOT_STATS_EN
    chk("bp_drops", 32'(drop_count), 5);
`endif

    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_pix", 32'(pix_count), 0);
`ifdef PLOT_STATS_EN
    chk("clr_drops", 32'(drop_count), 0);
`endif

    // Full FIFO with simultaneous pop and push
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      plot(20 + i, 0, i);
      tick();
    end
    chk("fp_full", 32'(dut.w_count), 4);
    mem_ready = 1'b1;
    plot(30, 0, 6);
    tick();
    vga_plot = 1'b0;
    mem_ready = 1'b0;
    chk("fp_count", 32'(dut.w_count), 4);
    chk("fp_overflow", 32'(overflow), 0);
    chk("fp_head", 32'(mem_addr), 21);
    mem_ready = 1'b1;
    chk("fp_d0", 32'(mem_addr), 21);
    tick();
    chk("fp_d1", 32'(mem_addr), 22);
    tick();
    chk("fp_d2", 32'(mem_addr), 23);
    tick();
    chk("fp_d3", 32'(mem_addr), 30);
    chk("fp_d3_col", 32'(mem_colour), 6);
    tick();
    chk("fp_empty", 32'(mem_wr), 0);
    chk("fp_pix", 32'(pix_count), 5);

    // Asynchronous reset with 3 entries queued
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      plot(40 + i, 1, 1);
      tick();
    end
    vga_plot = 1'b0;
    chk("mr_busy_pre", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_wr", 32'(mem_wr), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_pix", 32'(pix_count), 0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mr_no_stale%0d", i), 32'(mem_wr), 0);
    end
    chk("mr_addr", 32'(mem_addr), 0);

    // Full-screen sweep, fillscreen order
    for (int x = 0; x < 160; x++) begin
      for (int y = 0; y < 120; y++) begin
        plot(x, y, x % 8);
        tick();
        exp_addr = y * 160 + x;
        if (mem_wr !== 1'b1 || 32'(mem_addr) !== 32'(exp_addr)
            || 32'(mem_colour) !== 32'(x % 8)) begin
          if (sweep_first < 0) sweep_first = exp_addr;
          sweep_bad++;
        end
      end
    end
    vga_plot = 1'b0;
    chk("sweep_bad_writes", 32'(sweep_bad), 0);
    chk("sweep_last_addr", 32'(mem_addr), 19199);
    chk("sweep_last_col", 32'(mem_colour), 7);
    tick();
    chk("sweep_pix", 32'(pix_count), 19200);
    chk("sweep_overflow", 32'(overflow), 0);
    plot(1, 1, 1);
    tick();
    vga_plot = 1'b0;
    tick();
    chk("sat_pix", 32'(pix_count), 19200);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
